// File: rtl/fwrisc_uart_loader.sv
// ---------------------------------------------------------------------------
// fwrisc_uart_loader
//
// Loads a program image from the UART receive byte stream into the fwrisc
// instruction RAM. Bytes are packed little-endian into 32-bit words and
// written at sequential word addresses. Every accepted byte is acknowledged
// with a one-cycle program_receiving pulse so the host can pace itself. The
// fwrisc core is held in reset until a complete image has been loaded.
//
// Optional feature: define FWRISC_LOADER_CHECKSUM_EN to expect one trailing
// checksum byte (8-bit sum of all data bytes). A mismatch sets program_err
// and keeps the core in reset.
//
// Parameters:
//   PROG_BYTES      image size in bytes (multiple of 4, >= 4)
//   TIMEOUT_CYCLES  max idle gap between bytes during a load (>= 2)
//   AW              word-address width
//
// Ports:
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   rx_data[7:0]      received byte, valid with rx_valid
//   rx_valid          one-cycle strobe per received byte
//   mem_we            instruction-RAM word write strobe
//   mem_addr[AW-1:0]  word address
//   mem_wdata[31:0]   write data
//   program_receiving one-cycle ack per accepted byte
//   program_done      image complete (sticky until reset)
//   program_ov        byte received after done (sticky until reset)
//   program_err       checksum mismatch (sticky; 0 without the checksum)
//   core_rst          active-high reset to the fwrisc core
// ---------------------------------------------------------------------------
module fwrisc_uart_loader #(
    parameter int PROG_BYTES     = 4096,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int AW             = ((PROG_BYTES / 4) > 1) ? $clog2(PROG_BYTES / 4) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          program_receiving,
    output logic          program_done,
    output logic          program_ov,
    output logic          program_err,
    output logic          core_rst
);

    // One extra counter bit so the count can reach PROG_BYTES without wrapping.
    localparam int CW = $clog2(PROG_BYTES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_IDX = CW'(PROG_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
`ifdef FWRISC_LOADER_CHECKSUM_EN
        S_CHK  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t        r_state,     w_state_next;
    logic [CW-1:0] r_cnt,       w_cnt_next;
    logic [TW-1:0] r_to_cnt,    w_to_next;
    logic [23:0]   r_acc,       w_acc_next;   // lanes 0..2 of the word in progress
    logic          r_mem_we,    w_we_next;
    logic [AW-1:0] r_mem_addr,  w_addr_next;
    logic [31:0]   r_mem_wdata, w_wdata_next;
    logic          r_ack,       w_ack_next;
    logic          r_ov,        w_ov_next;
    logic          w_take_byte;
    logic          w_expire;
`ifdef FWRISC_LOADER_CHECKSUM_EN
    logic [7:0]    r_sum,       w_sum_next;
    logic          r_err,       w_err_next;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_to_next    = r_to_cnt;
        w_acc_next   = r_acc;
        w_we_next    = 1'b0;
        w_addr_next  = r_mem_addr;
        w_wdata_next = r_mem_wdata;
        w_ack_next   = 1'b0;
        w_ov_next    = r_ov;
        w_take_byte  = 1'b0;
        w_expire     = 1'b0;
`ifdef FWRISC_LOADER_CHECKSUM_EN
        w_sum_next   = r_sum;
        w_err_next   = r_err;
`endif

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_take_byte = 1'b1;
                end
            end
            S_RECV: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    w_take_byte = 1'b1;
                end else if (r_to_cnt == TO_LAST) begin
                    w_expire = 1'b1;
                end else begin
                    w_to_next = r_to_cnt + TW'(1);
                end
            end
`ifdef FWRISC_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) begin
                    w_ack_next   = 1'b1;
                    w_to_next    = '0;
                    w_state_next = S_DONE;
                    if (rx_data != r_sum) begin
                        w_err_next = 1'b1;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_expire = 1'b1;
                end else begin
                    w_to_next = r_to_cnt + TW'(1);
                end
            end
`endif
            S_DONE: begin
                if (rx_valid) begin
                    w_ov_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_take_byte) begin
            w_ack_next = 1'b1;
            w_to_next  = '0;
            w_cnt_next = r_cnt + CW'(1);
`ifdef FWRISC_LOADER_CHECKSUM_EN
            w_sum_next = r_sum + rx_data;
`endif
            case (r_cnt[1:0])
                2'd0: w_acc_next[7:0]   = rx_data;
                2'd1: w_acc_next[15:8]  = rx_data;
                2'd2: w_acc_next[23:16] = rx_data;
                default: begin
                    w_we_next    = 1'b1;
                    w_addr_next  = r_cnt[AW+1:2];
                    w_wdata_next = {rx_data, r_acc};
                end
            endcase
            if (r_cnt == LAST_IDX) begin
`ifdef FWRISC_LOADER_CHECKSUM_EN
                w_state_next = S_CHK;
`else
                w_state_next = S_DONE;
`endif
            end else begin
                w_state_next = S_RECV;
            end
        end

        // Abandon the partial image silently; the next byte starts at address 0.
        if (w_expire) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_to_next    = '0;
            w_acc_next   = '0;
`ifdef FWRISC_LOADER_CHECKSUM_EN
            w_sum_next   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_to_cnt    <= '0;
            r_acc       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ack       <= 1'b0;
            r_ov        <= 1'b0;
`ifdef FWRISC_LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_to_cnt    <= w_to_next;
            r_acc       <= w_acc_next;
            r_mem_we    <= w_we_next;
            r_mem_addr  <= w_addr_next;
            r_mem_wdata <= w_wdata_next;
            r_ack       <= w_ack_next;
            r_ov        <= w_ov_next;
`ifdef FWRISC_LOADER_CHECKSUM_EN
            r_sum       <= w_sum_next;
            r_err       <= w_err_next;
`endif
        end
    end

    assign mem_we            = r_mem_we;
    assign mem_addr          = r_mem_addr;
    assign mem_wdata         = r_mem_wdata;
    assign program_receiving = r_ack;
    assign program_done      = (r_state == S_DONE);
    assign program_ov        = r_ov;
`ifdef FWRISC_LOADER_CHECKSUM_EN
    assign program_err       = r_err;
    // A bad checksum leaves the core in reset even though loading finished.
    assign core_rst          = (r_state != S_DONE) || r_err;
`else
    assign program_err       = 1'b0;
    assign core_rst          = (r_state != S_DONE);
`endif

endmodule

// File: tb/tb_fwrisc_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_fwrisc_uart_loader
//
// Directed testbench for fwrisc_uart_loader with an 8-byte image and a
// 24-cycle inter-byte timeout. Expected words and flags are hand-computed.
// ---------------------------------------------------------------------------
module tb_fwrisc_uart_loader;

    localparam int PB = 8;
    localparam int TO = 24;
`ifdef FWRISC_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        mem_we;
    logic [0:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        program_receiving;
    logic        program_done;
    logic        program_ov;
    logic        program_err;
    logic        core_rst;

    int n_checks = 0;
    int n_errors = 0;

    fwrisc_uart_loader #(
        .PROG_BYTES     (PB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .program_receiving (program_receiving),
        .program_done      (program_done),
        .program_ov        (program_ov),
        .program_err       (program_err),
        .core_rst          (core_rst)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one byte for one cycle; check the registered response right after
    // the sampling edge. Back-to-back calls keep rx_valid high continuously.
    task automatic put_byte(input string tag, input logic [7:0] b, input logic exp_ack,
                            input logic exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        $display("%s byte 0x%02h: ack=%0d we=%0d addr=%0d data=0x%08h done=%0d ov=%0d err=%0d core_rst=%0d",
                 tag, b, program_receiving, mem_we, mem_addr, mem_wdata,
                 program_done, program_ov, program_err, core_rst);
        check_eq({tag, " ack"}, 32'(program_receiving), 32'(exp_ack));
        check_eq({tag, " mem_we"}, 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            check_eq({tag, " mem_addr"}, 32'(mem_addr), exp_addr);
            check_eq({tag, " mem_wdata"}, mem_wdata, exp_data);
        end
    endtask

    // Idle cycles; the pulses of the previous byte must be gone after one cycle.
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                check_eq({tag, " idle ack"}, 32'(program_receiving), 32'd0);
                check_eq({tag, " idle mem_we"}, 32'(mem_we), 32'd0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " mem_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, " mem_wdata"}, mem_wdata, 32'd0);
        check_eq({tag, " ack"}, 32'(program_receiving), 32'd0);
        check_eq({tag, " done"}, 32'(program_done), 32'd0);
        check_eq({tag, " ov"}, 32'(program_ov), 32'd0);
        check_eq({tag, " err"}, 32'(program_err), 32'd0);
        check_eq({tag, " core_rst"}, 32'(core_rst), 32'd1);
    endtask

    // Reset takes effect asynchronously: outputs are checked 1 time unit after assertion.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        $display("%s reset asserted", tag);
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Send an 8-byte image base..base+7 with 'gap' idle cycles between bytes.
    task automatic load_image(input string tag, input logic [7:0] base, input int gap,
                              input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < PB; i++) begin
            put_byte(tag, base + 8'(i), 1'b1, (i % 4) == 3, 32'(i / 4), (i < 4) ? w0 : w1);
            if (i == PB - 2) begin
                check_eq({tag, " done before last"}, 32'(program_done), 32'd0);
            end
            if (i < PB - 1 && gap > 0) begin
                idle(tag, gap);
            end
        end
        check_eq({tag, " done after last"}, 32'(program_done), CHK_EN ? 32'd0 : 32'd1);
        check_eq({tag, " core_rst after last"}, 32'(core_rst), CHK_EN ? 32'd1 : 32'd0);
    endtask

    initial begin
        #2;
        do_reset("reset");

        // Test 1: bytes 01..08, one per 20 cycles.
        load_image("t1", 8'h01, 19, 32'h04030201, 32'h08070605);
`ifdef FWRISC_LOADER_CHECKSUM_EN
        put_byte("t1 csum", 8'h24, 1'b1, 1'b0, 32'd0, 32'd0);
        check_eq("t1 csum done", 32'(program_done), 32'd1);
        check_eq("t1 csum err", 32'(program_err), 32'd0);
        check_eq("t1 csum core_rst", 32'(core_rst), 32'd0);
`endif

        // Test 2: byte after done is an overflow, not acked, not written.
        put_byte("t2", 8'hAA, 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("t2 ov", 32'(program_ov), 32'd1);
        check_eq("t2 done", 32'(program_done), 32'd1);
        check_eq("t2 core_rst", 32'(core_rst), 32'd0);

        do_reset("t3 reset");

        // Test 3: partial load of 3 bytes, then idle past the timeout.
        put_byte("t3 partial", 8'h21, 1'b1, 1'b0, 32'd0, 32'd0);
        idle("t3 partial", 1);
        put_byte("t3 partial", 8'h22, 1'b1, 1'b0, 32'd0, 32'd0);
        idle("t3 partial", 1);
        put_byte("t3 partial", 8'h23, 1'b1, 1'b0, 32'd0, 32'd0);
        idle("t3 timeout", 30);
        check_eq("t3 done after timeout", 32'(program_done), 32'd0);
        check_eq("t3 core_rst after timeout", 32'(core_rst), 32'd1);
        // Fresh load restarting at byte 0; a 23-cycle gap puts each byte on the
        // very edge the timeout would expire, so the byte must win.
        load_image("t3", 8'h11, TO - 1, 32'h14131211, 32'h18171615);

        do_reset("t4 reset");

        // Test 4: reset in the middle of a load, right while an ack is high.
        for (int i = 0; i < 5; i++) begin
            put_byte("t4 partial", 8'h01 + 8'(i), 1'b1, i == 3, 32'd0, 32'h04030201);
        end
        do_reset("t4 midload");

        // Test 5: full reload back-to-back, one byte per cycle.
        load_image("t5", 8'h01, 0, 32'h04030201, 32'h08070605);
`ifdef FWRISC_LOADER_CHECKSUM_EN
        put_byte("t5 csum bad", 8'h25, 1'b1, 1'b0, 32'd0, 32'd0);
        check_eq("t5 csum done", 32'(program_done), 32'd1);
        check_eq("t5 csum err", 32'(program_err), 32'd1);
        check_eq("t5 csum core_rst", 32'(core_rst), 32'd1);
`endif
        idle("t5 tail", 2);
        check_eq("t5 done sticky", 32'(program_done), 32'd1);
        check_eq("t5 ov clear", 32'(program_ov), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
